// File: rtl/risc16b_uart_pkg.sv
// risc16b_uart_pkg: shared definitions for the risc16b memory-mapped UART
// transmitter.
// Contents:
//   - word offsets of the register window
//   - the transmit FSM state type
//   - STATUS bit positions
package risc16b_uart_pkg;

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_DIV    = 2'd2;
  localparam logic [1:0] OFS_CTRL   = 2'd3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;

endpackage

// File: rtl/risc16b_uart_tx_fifo.sv
// uart_fifo: synchronous byte FIFO for the UART transmitter.
// Ports:
//   clk, rst (async, active-high)
//   push_i/din_i   write a byte; ignored when full unless pop_i is also high
//   pop_i/dout_o   dout_o shows the head entry; pop_i removes it
//   full_o, empty_o, count_o (entries held, $clog2(DEPTH)+1 bits)
module uart_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [7:0]    din_i,
  input  logic          pop_i,
  output logic [7:0]    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/risc16b_uart_tx.sv
// risc16b_uart_tx: memory-mapped 8N1 UART transmitter on the risc16b d-port.
// Window BASE..BASE+5 (+6 with RISC16B_UART_IRQ_EN):
//   +0 TXDATA (push), +2 STATUS, +4 DIV, +6 CTRL (irq build only).
// Ports:
//   clk, rst (async, active-high)
//   d_addr, d_oe, d_we, d_dout   CPU data port
//   sel, rdata                   combinational read path for the CPU mux
//   tx                           serial line, idle high
//   irq                          only when RISC16B_UART_IRQ_EN is defined
module risc16b_uart_tx
  import risc16b_uart_pkg::*;
#(
  parameter logic [15:0] BASE        = 16'hFF00,
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  input  logic [1:0]  d_we,
  input  logic [15:0] d_dout,
  output logic        sel,
  output logic [15:0] rdata,
  output logic        tx
`ifdef RISC16B_UART_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          win_hit, mapped, wr;
  logic [1:0]    ofs;
  logic          push, pop, full, empty;
  logic [7:0]    push_byte, fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [4:0]    cnt_ext;
  logic [15:0]   status;
  logic [15:0]   div_q;
  logic          ovf_q;
  logic          busy;

  uart_state_t   state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  assign win_hit = (d_addr[15:3] == BASE[15:3]);
  assign ofs     = d_addr[2:1];
`ifdef RISC16B_UART_IRQ_EN
  assign mapped  = 1'b1;
`else
  assign mapped  = (ofs != OFS_CTRL);
`endif
  assign sel     = d_oe & win_hit & mapped;
  assign wr      = win_hit & mapped & (d_we != 2'b00);
  assign push    = wr & (ofs == OFS_TXDATA);
  // Even byte store (d_we=01) carries its data in the high lane.
  assign push_byte = (d_we == 2'b01) ? d_dout[15:8] : d_dout[7:0];
  assign busy    = (state_q != IDLE);

  uart_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_byte),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign cnt_ext = 5'(fifo_count);

  always_comb begin
    status                    = '0;
    status[ST_EMPTY]          = empty;
    status[ST_FULL]           = full;
    status[ST_BUSY]           = busy;
    status[ST_OVF]            = ovf_q;
    status[ST_CNT_LO +: 4]    = cnt_ext[3:0];
  end

`ifdef RISC16B_UART_IRQ_EN
  logic ctrl_q;
  logic irq_q;
  assign irq = irq_q;
`endif

  always_comb begin
    rdata = '0;
    if (win_hit) begin
      case (ofs)
        OFS_STATUS: rdata = status;
        OFS_DIV:    rdata = div_q;
`ifdef RISC16B_UART_IRQ_EN
        OFS_CTRL:   rdata = {15'b0, ctrl_q};
`endif
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DEFAULT_DIV;
      ovf_q <= 1'b0;
    end else begin
      if (wr && ofs == OFS_DIV && d_we == 2'b11) div_q <= d_dout;
      if (wr && ofs == OFS_STATUS)               ovf_q <= 1'b0;
      else if (push && full && !pop)             ovf_q <= 1'b1;
    end
  end

`ifdef RISC16B_UART_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr && ofs == OFS_CTRL && d_we == 2'b11) ctrl_q <= d_dout[0];
      irq_q <= ctrl_q & empty & ~busy;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // FSM next-state logic; every bit period ends when the counter hits 0,
  // and the reload samples div_q at that moment.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = div_q;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = div_q;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d  = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = div_q;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            baud_d  = div_q;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output logic; tx is registered from the next state so it never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_risc16b_uart_tx.sv
module tb_risc16b_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_addr;
  logic        d_oe;
  logic [1:0]  d_we;
  logic [15:0] d_dout;
  logic        sel;
  logic [15:0] rdata;
  logic        tx;
`ifdef RISC16B_UART_IRQ_EN
  logic        irq;
`endif

  int ntests = 0;
  int nfail  = 0;

  risc16b_uart_tx dut (
    .clk    (clk),
    .rst    (rst),
    .d_addr (d_addr),
    .d_oe   (d_oe),
    .d_we   (d_we),
    .d_dout (d_dout),
    .sel    (sel),
    .rdata  (rdata),
    .tx     (tx)
`ifdef RISC16B_UART_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [1:0] we, input logic [15:0] data);
    d_addr = addr;
    d_we   = we;
    d_dout = data;
    tick();
    d_we   = 2'b00;
  endtask

  task automatic rd(input logic [15:0] addr, output logic [15:0] data, output logic s);
    d_addr = addr;
    d_oe   = 1'b1;
    #1;
    data   = rdata;
    s      = sel;
    d_oe   = 1'b0;
  endtask

  // Checks tx (and busy) for samples k0.. of a frame whose start edge is
  // sample 0: start_len cycles low, 8 data bits of bit_len, one stop bit.
  task automatic expect_frame(input logic [7:0] b, input int start_len, input int bit_len,
                              input int k0);
    logic [15:0] st;
    logic        s;
    logic        e;
    int          total;
    int          j;
    total = start_len + 9 * bit_len;
    for (int k = k0; k < total; k++) begin
      tick();
      if (k < start_len) e = 1'b0;
      else begin
        j = (k - start_len) / bit_len;
        e = (j < 8) ? b[j] : 1'b1;
      end
      chk("frame_tx", {15'b0, tx}, {15'b0, e});
      rd(16'hFF02, st, s);
      chk("frame_busy", {15'b0, st[2]}, 16'h0001);
`ifdef RISC16B_UART_IRQ_EN
      chk("frame_irq", {15'b0, irq}, 16'h0000);
`endif
    end
  endtask

  logic [15:0] rv;
  logic        sv;

  initial begin
    rst    = 1'b1;
    d_addr = 16'h0000;
    d_oe   = 1'b0;
    d_we   = 2'b00;
    d_dout = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("reset_tx", {15'b0, tx}, 16'h0001);
    rd(16'hFF02, rv, sv);
    chk("reset_status", rv, 16'h0001);
    chk("reset_status_sel", {15'b0, sv}, 16'h0001);
    rd(16'hFF04, rv, sv);
    chk("reset_div", rv, 16'h01B1);
    rd(16'hFF00, rv, sv);
    chk("txdata_reads_0", rv, 16'h0000);
    rd(16'hFE02, rv, sv);
    chk("outwin_sel", {15'b0, sv}, 16'h0000);
    chk("outwin_rdata", rv, 16'h0000);
    rd(16'hFF06, rv, sv);
`ifdef RISC16B_UART_IRQ_EN
    chk("ctrl_sel", {15'b0, sv}, 16'h0001);
    chk("ctrl_reset", rv, 16'h0000);
`else
    chk("ofs6_sel", {15'b0, sv}, 16'h0000);
    chk("ofs6_rdata", rv, 16'h0000);
`endif

    // DIV programming, byte writes ignored
    wr(16'hFF04, 2'b11, 16'h0003);
    wr(16'hFF04, 2'b01, 16'h7700);
    wr(16'hFF04, 2'b10, 16'h0077);
    rd(16'hFF04, rv, sv);
    chk("div_word_only", rv, 16'h0003);
    wr(16'hFE00, 2'b11, 16'h00AA);
    rd(16'hFF02, rv, sv);
    chk("outwin_no_push", rv, 16'h0001);

    // word store of 0x55: 40-cycle frame
    wr(16'hFF00, 2'b11, 16'h0055);
    chk("pre_start_tx", {15'b0, tx}, 16'h0001);
    expect_frame(8'h55, 4, 4, 0);
    tick();
    rd(16'hFF02, rv, sv);
    chk("after_55_status", rv, 16'h0001);
    chk("after_55_tx", {15'b0, tx}, 16'h0001);

    // even byte store carries high lane
    wr(16'hFF00, 2'b01, 16'hA500);
    expect_frame(8'hA5, 4, 4, 0);
    tick();

    // odd byte store carries low lane
    wr(16'hFF00, 2'b10, 16'h3C77);
    expect_frame(8'h77, 4, 4, 0);
    tick();

    // overflow: 0xF0 starts a frame, then 1..9 pushed back to back
    wr(16'hFF00, 2'b11, 16'h00F0);
    for (int i = 1; i <= 9; i++) wr(16'hFF00, 2'b11, 16'(i));
    rd(16'hFF02, rv, sv);
    chk("ovf_status", rv, 16'h008E);
    wr(16'hFF02, 2'b11, 16'h0000);
    rd(16'hFF02, rv, sv);
    chk("ovf_cleared", rv, 16'h0086);
    expect_frame(8'hF0, 4, 4, 10);
    for (int i = 1; i <= 8; i++) expect_frame(8'(i), 4, 4, 0);
    tick();
    rd(16'hFF02, rv, sv);
    chk("after_burst_status", rv, 16'h0001);

    // DIV change during start bit
    wr(16'hFF00, 2'b11, 16'h005A);
    tick();
    chk("divchg_k0", {15'b0, tx}, 16'h0000);
    wr(16'hFF04, 2'b11, 16'h0001);
    chk("divchg_k1", {15'b0, tx}, 16'h0000);
    rd(16'hFF04, rv, sv);
    chk("divchg_read", rv, 16'h0001);
    chk("divchg_sel", {15'b0, sv}, 16'h0001);
    expect_frame(8'h5A, 4, 2, 2);
    tick();
    rd(16'hFF02, rv, sv);
    chk("after_divchg_status", rv, 16'h0001);

    // asynchronous reset during DATA bit 4
    wr(16'hFF04, 2'b11, 16'h0003);
    wr(16'hFF00, 2'b11, 16'h0000);
    for (int k = 0; k < 22; k++) tick();
    chk("pre_rst_tx", {15'b0, tx}, 16'h0000);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_tx_immediate", {15'b0, tx}, 16'h0001);
    #2;
    rst = 1'b0;
    rd(16'hFF02, rv, sv);
    chk("post_rst_status", rv, 16'h0001);
    rd(16'hFF04, rv, sv);
    chk("post_rst_div", rv, 16'h01B1);
    tick();
    chk("post_rst_tx", {15'b0, tx}, 16'h0001);

`ifdef RISC16B_UART_IRQ_EN
    wr(16'hFF04, 2'b11, 16'h0003);
    wr(16'hFF06, 2'b11, 16'h0001);
    tick();
    chk("irq_idle", {15'b0, irq}, 16'h0001);
    wr(16'hFF00, 2'b11, 16'h00C3);
    expect_frame(8'hC3, 4, 4, 0);
    tick();
    chk("irq_enter_idle", {15'b0, irq}, 16'h0000);
    tick();
    chk("irq_after_idle", {15'b0, irq}, 16'h0001);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
